wakeup_sequencer: RTL

WAKEUP_SEQUENCER -- requirements
Module: wakeup_sequencer

---
 rtl/wakeup_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wakeup_sequencer.sv
// Power-domain wakeup sequencer: synchronised wakeup edge -> power up -> de-isolate -> active -> shutdown.
// Optional accepted-wakeup counter is built only when WAKE_CNT_EN is defined.
module wakeup_sequencer #(
  parameter int PWR_DLY = 16,
  parameter int ISO_DLY = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       wakeup,
  input  logic       sleep_req,
  output logic       pwr_en,
  output logic       iso_en,
  output logic       run,
  output logic       cnt_clr,
  output logic [2:0] state,
  output logic [7:0] wake_cnt
);

  // state  | meaning
  // SLEEP  | domain off, isolated, waiting for wakeup edge or pending wakeup
  // PWRUP  | power switch on, waiting PWR_DLY cycles for supply to settle
  // DEISO  | isolation released, waiting ISO_DLY cycles before run
  // ACTIVE | domain released, waiting for sleep_req
  // SHUTDN | isolation re-applied, waiting ISO_DLY cycles before power off
  typedef enum logic [2:0] {
    SLEEP  = 3'd0,
    PWRUP  = 3'd1,
    DEISO  = 3'd2,
    ACTIVE = 3'd3,
    SHUTDN = 3'd4
  } state_t;

  localparam logic [7:0] PWR_LD = 8'(PWR_DLY);
  localparam logic [7:0] ISO_LD = 8'(ISO_DLY);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       pend_q, pend_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic       wk_edge;
  logic       tmr_done;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= wakeup;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign wk_edge  = sync2_q & ~sync3_q;
  // Terminal count at 1 so a timed state lasts exactly its load value.
  assign tmr_done = (timer_q <= 8'd1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= SLEEP;
      timer_q   <= 8'd0;
      pend_q    <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pend_d    = pend_q;
    cnt_clr_d = 1'b0;
    pwr_en    = 1'b0;
    iso_en    = 1'b1;
    run       = 1'b0;
    case (state_q)
      SLEEP: begin
        if (wk_edge || pend_q) begin
          state_d = PWRUP;
          timer_d = PWR_LD;
          pend_d  = 1'b0;
        end
      end
      PWRUP: begin
        pwr_en = 1'b1;
        if (tmr_done) begin
          state_d = DEISO;
          timer_d = ISO_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      DEISO: begin
        pwr_en = 1'b1;
        iso_en = 1'b0;
        if (tmr_done) begin
          state_d   = ACTIVE;
          timer_d   = 8'd0;
          cnt_clr_d = 1'b1;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      ACTIVE: begin
        pwr_en = 1'b1;
        iso_en = 1'b0;
        run    = 1'b1;
        if (sleep_req) begin
          state_d = SHUTDN;
          timer_d = ISO_LD;
        end
      end
      SHUTDN: begin
        pwr_en = 1'b1;
        if (wk_edge) pend_d = 1'b1;
        if (tmr_done) begin
          state_d = SLEEP;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin
        state_d = SLEEP;
        timer_d = 8'd0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign state   = state_q;
  assign cnt_clr = cnt_clr_q;

`ifdef WAKE_CNT_EN
  logic [7:0] wake_cnt_q, wake_cnt_d;
  logic       wake_acc;

  assign wake_acc = (state_q == SLEEP) && (wk_edge || pend_q);

  always_comb begin
    wake_cnt_d = wake_cnt_q;
    if (wake_acc && (wake_cnt_q != 8'hFF)) wake_cnt_d = wake_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) wake_cnt_q <= 8'd0;
    else     wake_cnt_q <= wake_cnt_d;
  end

  assign wake_cnt = wake_cnt_q;
`else
  assign wake_cnt = 8'd0;
`endif

endmodule
